// File: rtl/store_unit_pkg.sv
// Pipeline definitions shared by the load and store paths.
// Holds the load/store select encodings, the store FSM state type, the
// big-endian byte-lane constant and the memory write payload struct.
package store_unit_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned SEL_W  = 3;

  // Load select encodings (consumed by the load alignment logic)
  localparam logic [SEL_W-1:0] LD_SEL_LB  = 3'd0;
  localparam logic [SEL_W-1:0] LD_SEL_LH  = 3'd1;
  localparam logic [SEL_W-1:0] LD_SEL_LW  = 3'd2;
  localparam logic [SEL_W-1:0] LD_SEL_LWL = 3'd3;
  localparam logic [SEL_W-1:0] LD_SEL_LWR = 3'd4;

  // Store select encodings, numerically paired with the load encodings
  localparam logic [SEL_W-1:0] SEL_SB  = 3'd0;
  localparam logic [SEL_W-1:0] SEL_SH  = 3'd1;
  localparam logic [SEL_W-1:0] SEL_SW  = 3'd2;
  localparam logic [SEL_W-1:0] SEL_SWL = 3'd3;
  localparam logic [SEL_W-1:0] SEL_SWR = 3'd4;

  // Big-endian: byte address 0 lives in the most significant lane
  localparam logic [BE_W-1:0] BE_LANE0 = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_e;

  // Data-memory write payload
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } mem_wr_t;

endpackage

// File: rtl/store_align.sv
// Store data alignment: places register data into big-endian byte lanes,
// produces byte enables and flags misaligned or illegal store selects.
// Purely combinational.
// Ports:
//   addr_lo  : low two bits of the byte address
//   sel      : store select (sb/sh/sw/swl/swr, 5-7 illegal)
//   data     : rt register value
//   wdata    : lane-aligned write data
//   be       : byte enables, be[3] = byte address 0
//   misalign : address error (misaligned sh/sw or illegal select)
module store_align
  import store_unit_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] wdata,
  output logic [BE_W-1:0]   be,
  output logic              misalign
);

  // Lane placement per store type; swl/swr cover the partial-word cases
  always_comb begin
    wdata    = '0;
    be       = '0;
    misalign = 1'b0;
    case (sel)
      SEL_SB: begin
        wdata = {4{data[7:0]}};
        be    = BE_LANE0 >> addr_lo;
      end
      SEL_SH: begin
        wdata    = {2{data[15:0]}};
        be       = addr_lo[1] ? 4'b0011 : 4'b1100;
        misalign = addr_lo[0];
      end
      SEL_SW: begin
        wdata    = data;
        be       = 4'b1111;
        misalign = (addr_lo != 2'b00);
      end
      SEL_SWL: begin
        wdata = data >> {addr_lo, 3'b000};
        be    = 4'b1111 >> addr_lo;
      end
      SEL_SWR: begin
        // ~addr_lo == 3 - addr_lo
        wdata = data << {~addr_lo, 3'b000};
        be    = 4'b1111 << ~addr_lo;
      end
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store unit: accepts one store op via valid/ready, aligns it and
// drives the data-memory write port with a req/gnt handshake. Reports
// address errors (ades) and write timeouts (bus_err).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : op handshake (ready only in IDLE)
//   in_addr, in_sel, in_data   : store op
//   mem_req/mem_gnt            : write request handshake
//   mem_addr, mem_wdata, mem_be: write payload (word address)
//   done, ades, bus_err        : one-cycle completion/fault pulses
//   ades_addr                  : faulting address, held until next fault
module store_unit
  import store_unit_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  output logic              done,
  output logic              ades,
  output logic [ADDR_W-1:0] ades_addr,
  output logic              bus_err
);

  state_e            state;
  logic [CNT_W-1:0]  wait_cnt;
  mem_wr_t           wr_q;
  logic [DATA_W-1:0] al_wdata;
  logic [BE_W-1:0]   al_be;
  logic              al_misalign;
  logic              accept;

  store_align u_align (
    .addr_lo  (in_addr[1:0]),
    .sel      (in_sel),
    .data     (in_data),
    .wdata    (al_wdata),
    .be       (al_be),
    .misalign (al_misalign)
  );

  assign in_ready  = (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign mem_addr  = wr_q.addr;
  assign mem_wdata = wr_q.wdata;
  assign mem_be    = wr_q.be;

  // FSM, wait counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      wr_q      <= '0;
      mem_req   <= 1'b0;
      done      <= 1'b0;
      ades      <= 1'b0;
      ades_addr <= '0;
      bus_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      ades    <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (al_misalign) begin
              ades      <= 1'b1;
              ades_addr <= in_addr;
            end else begin
              wr_q.addr  <= {in_addr[ADDR_W-1:2], 2'b00};
              wr_q.wdata <= al_wdata;
              wr_q.be    <= al_be;
              mem_req    <= 1'b1;
              wait_cnt   <= '0;
              state      <= REQ;
            end
          end
        end
        REQ: begin
          // A grant in the final wait cycle still completes the write
          if (mem_gnt) begin
            done     <= 1'b1;
            mem_req  <= 1'b0;
            wr_q.be  <= '0;
            wait_cnt <= '0;
            state    <= IDLE;
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            bus_err  <= 1'b1;
            mem_req  <= 1'b0;
            wr_q.be  <= '0;
            wait_cnt <= '0;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
